// File: rtl/mem_pkg.sv
// Shared memory-access definitions: access sizes, master FSM states and
// size/alignment helpers used by the bit-serial RAM master and the cache side.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    RD,
    RESP
  } state_e;

  function automatic logic [6:0] size_bits(size_e sz);
    case (sz)
      SZ_B:    return 7'd8;
      SZ_H:    return 7'd16;
      SZ_W:    return 7'd32;
      default: return 7'd64;
    endcase
  endfunction

  // Natural alignment: byte address must be a multiple of the access size in bytes.
  function automatic logic is_aligned(size_e sz, logic [2:0] addr_lo);
    case (sz)
      SZ_B:    return 1'b1;
      SZ_H:    return addr_lo[0] == 1'b0;
      SZ_W:    return addr_lo[1:0] == 2'b00;
      default: return addr_lo == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ram_bit_master_if.sv
// Request/response channel plus bit-addressed RAM port of the serial RAM master.
interface ram_bit_master_if #(
  parameter int MADDR_SZ = 32,
  parameter int DATA_W   = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [MADDR_SZ-4:0]   req_addr;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;
  logic [MADDR_SZ-1:0]   ram_addr;
  logic                  ram_datain;
  logic                  ram_we;
  logic                  ram_dataout;

  modport master (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata, ram_dataout,
    output req_ready, resp_valid, resp_rdata, resp_err, ram_addr, ram_datain, ram_we
  );

  modport slave (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata, ram_dataout,
    input  req_ready, resp_valid, resp_rdata, resp_err, ram_addr, ram_datain, ram_we
  );
endinterface

// File: rtl/load_extend.sv
// Sign/zero extension of a raw little-endian load value to 64 bits.
module load_extend
  import mem_pkg::*;
(
  input  size_e       size,
  input  logic        sign_ext,
  input  logic [63:0] raw,
  output logic [63:0] ext
);
  always_comb begin
    ext = raw;
    case (size)
      SZ_B:    ext = {{56{sign_ext & raw[7]}},  raw[7:0]};
      SZ_H:    ext = {{48{sign_ext & raw[15]}}, raw[15:0]};
      SZ_W:    ext = {{32{sign_ext & raw[31]}}, raw[31:0]};
      default: ext = raw;
    endcase
  end
endmodule

// File: rtl/ram_bit_master.sv
// Converts byte/half/word/dword loads and stores into serial single-bit RAM
// accesses with a registered write strobe and a one-cycle response pulse.
module ram_bit_master
  import mem_pkg::*;
#(
  parameter int MADDR_SZ = 32,
  parameter int DATA_W   = 64
) (
  input logic               clk,
  input logic               rst_n,
  ram_bit_master_if.master  bus
);
  state_e                state_q, state_d;
  logic                  op_we_q, op_we_d;
  logic [MADDR_SZ-1:0]   base_q, base_d;
  size_e                 size_q, size_d;
  logic                  sign_q, sign_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [5:0]            bit_q, bit_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [MADDR_SZ-1:0]   ram_addr_q, ram_addr_d;
  logic                  ram_datain_q, ram_datain_d;
  logic                  ram_we_q, ram_we_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
  logic                  req_ready_q, req_ready_d;

  logic [5:0]            last_idx;
  logic [5:0]            bit_inc;
  logic [MADDR_SZ-1:0]   next_addr;
  logic [DATA_W-1:0]     rd_raw;
  logic [DATA_W-1:0]     rd_ext;
  logic                  transfer;
  size_e                 in_size;

  assign in_size   = size_e'(bus.req_size);
  assign transfer  = bus.req_valid & req_ready_q;
  assign last_idx  = 6'(size_bits(size_q) - 7'd1);
  assign bit_inc   = bit_q + 6'd1;
  assign next_addr = base_q + MADDR_SZ'(bit_inc);
  // rdata_q is cleared on acceptance, so OR-ing in the current bit is enough.
  assign rd_raw    = rdata_q | (DATA_W'(bus.ram_dataout) << bit_q);

  load_extend u_load_extend (
    .size     (size_q),
    .sign_ext (sign_q),
    .raw      (rd_raw),
    .ext      (rd_ext)
  );

  always_comb begin
    state_d      = state_q;
    op_we_d      = op_we_q;
    base_d       = base_q;
    size_d       = size_q;
    sign_d       = sign_q;
    wdata_d      = wdata_q;
    bit_d        = bit_q;
    rdata_d      = rdata_q;
    ram_addr_d   = ram_addr_q;
    ram_datain_d = ram_datain_q;
    ram_we_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          op_we_d = bus.req_we;
          base_d  = {bus.req_addr, 3'b000};
          size_d  = in_size;
          sign_d  = bus.req_signed;
          wdata_d = bus.req_wdata;
          bit_d   = 6'd0;
          rdata_d = '0;
          if (!is_aligned(in_size, bus.req_addr[2:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            ram_addr_d   = {bus.req_addr, 3'b000};
            ram_datain_d = bus.req_we & bus.req_wdata[0];
            state_d      = bus.req_we ? WR_SETUP : RD;
          end
        end
      end
      WR_SETUP: begin
        ram_we_d = 1'b1;
        state_d  = WR_STROBE;
      end
      // Strobe drops on the same edge the address advances; the RAM only acts on the rising edge.
      WR_STROBE: begin
        if (bit_q == last_idx) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          bit_d        = bit_inc;
          ram_addr_d   = next_addr;
          ram_datain_d = wdata_q[bit_inc];
          state_d      = WR_SETUP;
        end
      end
      RD: begin
        rdata_d = rd_raw;
        if (bit_q == last_idx) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = rd_ext;
        end else begin
          bit_d      = bit_inc;
          ram_addr_d = next_addr;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_we_q      <= 1'b0;
      base_q       <= '0;
      size_q       <= SZ_B;
      sign_q       <= 1'b0;
      wdata_q      <= '0;
      bit_q        <= 6'd0;
      rdata_q      <= '0;
      ram_addr_q   <= '0;
      ram_datain_q <= 1'b0;
      ram_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_we_q      <= op_we_d;
      base_q       <= base_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      wdata_q      <= wdata_d;
      bit_q        <= bit_d;
      rdata_q      <= rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_datain_q <= ram_datain_d;
      ram_we_q     <= ram_we_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_datain = ram_datain_q;
  assign bus.ram_we     = ram_we_q;
endmodule
